rip_mem_arbiter: RTL

//  Shares one single-port, byte-enabled block RAM between the instruction-fetch (IF) and

---
 rtl/rip_const.sv | 27 ++
 rtl/rip_mem_arb_tagpipe.sv | 47 ++++
 rtl/rip_mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rip_const.sv
// ============================================================================
// Module      : rip_const (package)
// Description : Shared types for the rip memory arbiter: the owner of a read
//               in flight and the tag that travels down the latency pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rip_const;

  // Which requester a read response belongs to.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } owner_t;

  // One slot of the read-tag pipeline.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_IF};

endpackage : rip_const

`default_nettype wire

// File: rtl/rip_mem_arb_tagpipe.sv
// ============================================================================
// Module      : rip_mem_arb_tagpipe
// Description : MEM_LATENCY-deep shift register of read tags. A tag entered in
//               the grant cycle appears on tag_out exactly MEM_LATENCY cycles
//               later, lined up with the RAM read data. rst flushes all slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rip_mem_arb_tagpipe
  import rip_const::*;
#(
  parameter int MEM_LATENCY = 1   // 1..4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [MEM_LATENCY-1:0] stage_q;
  tag_t [MEM_LATENCY-1:0] stage_d;

  // Next state: new tag enters slot 0, every other slot takes its predecessor.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tag storage with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[MEM_LATENCY-1];

endmodule : rip_mem_arb_tagpipe

`default_nettype wire

// File: rtl/rip_mem_arbiter.sv
// ============================================================================
// Module      : rip_mem_arbiter
// Description : Shares one single-port byte-enabled RAM between the IF and MA
//               requesters. Fixed MA priority, one combinational grant per
//               cycle, reads tagged and their data routed back to the owner
//               MEM_LATENCY cycles after the grant.
// Config      : RIP_MEM_ARB_STARVE_GUARD_EN - when defined, IF is forced to
//               win after STARVE_LIMIT consecutive MA grants while it waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rip_mem_arbiter
  import rip_const::*;
#(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int MEM_LATENCY  = 1,   // 1..4
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction fetch requester (read only)
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // Memory access requester (read or byte-enabled write)
  input  logic                  ma_req,
  input  logic [NUM_COL-1:0]    ma_we,
  input  logic [DATA_WIDTH-1:0] ma_addr,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic                  ma_gnt,
  output logic                  ma_rvalid,
  output logic [DATA_WIDTH-1:0] ma_rdata,
  // RAM port
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic                  if_first;      // starvation guard overrides MA priority
  tag_t                  tag_in;
  tag_t                  tag_out;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ma_rdata_q, ma_rdata_d;

`ifdef RIP_MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Count MA grants taken while IF is waiting; any IF grant or IF idle clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (ma_gnt) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign if_first = if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`else
  assign if_first = 1'b0;
`endif

  // Grant selection: MA wins ties unless the guard says IF has waited enough.
  // Nothing is granted while rst is high so the RAM port stays quiet.
  always_comb begin
    if_gnt = 1'b0;
    ma_gnt = 1'b0;
    if (!rst) begin
      if (ma_req && !if_first) begin
        ma_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Drive the RAM port from whichever requester was granted this cycle.
  always_comb begin
    mem_en    = if_gnt || ma_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ma_gnt) begin
      mem_we    = ma_we;
      mem_addr  = ma_addr[ADDR_WIDTH+1:2];
      mem_wdata = ma_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr[ADDR_WIDTH+1:2];
    end
  end

  // Every read grant (IF, or MA with no byte enables) launches an owner tag.
  always_comb begin
    tag_in       = TAG_NONE;
    tag_in.valid = if_gnt || (ma_gnt && (ma_we == '0));
    tag_in.owner = ma_gnt ? OWN_MA : OWN_IF;
  end

  rip_mem_arb_tagpipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Route returning data to its owner; the other side keeps its last word.
  always_comb begin
    if_rvalid  = !rst && tag_out.valid && (tag_out.owner == OWN_IF);
    ma_rvalid  = !rst && tag_out.valid && (tag_out.owner == OWN_MA);
    if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
    ma_rdata_d = ma_rvalid ? mem_rdata : ma_rdata_q;
    if_rdata   = rst ? '0 : if_rdata_d;
    ma_rdata   = rst ? '0 : ma_rdata_d;
  end

  // Hold registers for the last delivered word of each requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
    end else begin
      if_rdata_q <= if_rdata_d;
      ma_rdata_q <= ma_rdata_d;
    end
  end

  // Byte-offset and upper address bits never reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[DATA_WIDTH-1:ADDR_WIDTH+2], if_addr[1:0],
                              ma_addr[DATA_WIDTH-1:ADDR_WIDTH+2], ma_addr[1:0]};

`ifndef SYNTHESIS
  // A pending request must stay unchanged until it is accepted.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_gnt) |=> (if_req && $stable(if_addr)));

  a_ma_hold: assert property (@(posedge clk) disable iff (rst)
    (ma_req && !ma_gnt) |=> (ma_req && $stable({ma_we, ma_addr, ma_wdata})));

  a_one_gnt: assert property (@(posedge clk) !(if_gnt && ma_gnt));

  a_gnt_has_req: assert property (@(posedge clk)
    (!if_gnt || if_req) && (!ma_gnt || ma_req));
`endif

endmodule : rip_mem_arbiter

`default_nettype wire
